cga_scandoubler: RTL and testbench

Line-doubling stage that sits directly downstream of the CGA palette/composite colour stage. It accepts 18-bit RGB (6:6:6) pixels at the 15.7 kHz CGA line rate and writes each line into one half of a ping-pong line buffer. It replays the previous line twice at double pixel rate, so a VGA-class monitor receives 31.4 kHz lines. Single clock domain; input and output pixel rates are set by clock-enable strobes.

---
 rtl/cga_scandoubler_if.sv | 36 +++
 rtl/cga_scandoubler.sv | 116 +++++++++++
 tb/tb_cga_scandoubler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cga_scandoubler_if.sv
// Video pixel bus between the CGA colour stage, the scan doubler and the VGA output,
// plus read-only debug taps of the doubler's line state.
interface cga_scandoubler_if #(
    parameter int HCNT_W = 11
);
    // Strobe semantics: there is no backpressure. A pixel and its syncs are taken when
    // ce_in is high; each ce_out high advances the output by one pixel. Both are one clk wide.
    logic              ce_in;
    logic [5:0]        red_in;
    logic [5:0]        green_in;
    logic [5:0]        blue_in;
    logic              hsync_in;
    logic              vsync_in;
    logic              ce_out;
    logic [5:0]        red;
    logic [5:0]        green;
    logic [5:0]        blue;
    logic              hsync_out;
    logic              vsync_out;
    logic [HCNT_W-1:0] dbg_line_len;
    logic [HCNT_W-1:0] dbg_out_hcnt;
    logic              dbg_wbank;
    logic              dbg_rbank;

    modport master (
        output ce_in, red_in, green_in, blue_in, hsync_in, vsync_in, ce_out,
        input  red, green, blue, hsync_out, vsync_out,
        input  dbg_line_len, dbg_out_hcnt, dbg_wbank, dbg_rbank
    );

    modport slave (
        input  ce_in, red_in, green_in, blue_in, hsync_in, vsync_in, ce_out,
        output red, green, blue, hsync_out, vsync_out,
        output dbg_line_len, dbg_out_hcnt, dbg_wbank, dbg_rbank
    );
endinterface

// File: rtl/cga_scandoubler.sv
// CGA 15.7 kHz to 31.4 kHz line doubler: each input line is captured into one half of a
// ping-pong buffer while the previous line is replayed twice at double pixel rate.
module cga_scandoubler #(
    parameter int MAX_WIDTH = 1024,
    parameter int HCNT_W    = 11,
    parameter int HS_WIDTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    cga_scandoubler_if.slave  vid
);
    localparam int AW = $clog2(MAX_WIDTH);
    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [HCNT_W-1:0] MAXW     = HCNT_W'(MAX_WIDTH);
    localparam logic [HCNT_W-1:0] HSW      = HCNT_W'(HS_WIDTH);

    logic [17:0]       line_buf [2*MAX_WIDTH];
    logic [17:0]       rd_data;
    logic [HCNT_W-1:0] in_hcnt;
    logic [HCNT_W-1:0] out_hcnt;
    logic [HCNT_W-1:0] line_len;
    logic              hs_prev;
    logic              wbank;
    logic              rbank;
    logic              synced;
    logic              hs_rise;
    logic              wr_en;
    logic [AW:0]       wr_addr;
    logic [AW:0]       rd_addr;
    logic              s1_valid;
    logic              s1_hs;
    logic [17:0]       rgb_q;
    logic              hsync_q;
    logic              vsync_q;

    always_comb begin
        hs_rise = vid.ce_in & vid.hsync_in & ~hs_prev;
        wr_en   = vid.ce_in & (hs_rise | (in_hcnt < MAXW));
        wr_addr = hs_rise ? {~wbank, {AW{1'b0}}} : {wbank, in_hcnt[AW-1:0]};
        rd_addr = {rbank, out_hcnt[AW-1:0]};
    end

    // Buffer RAM: no reset, so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[wr_addr] <= {vid.blue_in, vid.green_in, vid.red_in};
        end
        rd_data <= line_buf[rd_addr];
    end

    // A line is only trusted once it started on an hsync edge; the partial line seen
    // after reset yields line_len 0, which keeps the output idle for one more line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_hcnt  <= '0;
            line_len <= '0;
            hs_prev  <= 1'b0;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            synced   <= 1'b0;
            vsync_q  <= 1'b0;
        end else if (vid.ce_in) begin
            hs_prev <= vid.hsync_in;
            vsync_q <= vid.vsync_in;
            if (hs_rise) begin
                line_len <= synced ? ((in_hcnt > MAXW) ? MAXW : in_hcnt) : '0;
                synced   <= 1'b1;
                rbank    <= wbank;
                wbank    <= ~wbank;
                in_hcnt  <= HCNT_W'(1);
            end else if (in_hcnt != HCNT_MAX) begin
                in_hcnt <= in_hcnt + 1'b1;
            end
        end
    end

    // The restart from a new input line wins over the replay wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hcnt <= '0;
        end else if (hs_rise) begin
            out_hcnt <= '0;
        end else if (vid.ce_out) begin
            if ((line_len == '0) || (out_hcnt == line_len - 1'b1)) begin
                out_hcnt <= '0;
            end else begin
                out_hcnt <= out_hcnt + 1'b1;
            end
        end
    end

    // Two-stage output pipe: stage 1 runs alongside the RAM read, stage 2 registers pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_hs    <= 1'b0;
            rgb_q    <= '0;
            hsync_q  <= 1'b0;
        end else begin
            s1_valid <= (line_len != '0) && (out_hcnt < MAXW);
            s1_hs    <= (line_len != '0) && (out_hcnt < HSW);
            rgb_q    <= s1_valid ? rd_data : '0;
            hsync_q  <= s1_hs;
        end
    end

    assign vid.red          = rgb_q[5:0];
    assign vid.green        = rgb_q[11:6];
    assign vid.blue         = rgb_q[17:12];
    assign vid.hsync_out    = hsync_q;
    assign vid.vsync_out    = vsync_q;
    assign vid.dbg_line_len = line_len;
    assign vid.dbg_out_hcnt = out_hcnt;
    assign vid.dbg_wbank    = wbank;
    assign vid.dbg_rbank    = rbank;
endmodule

// File: tb/tb_cga_scandoubler.sv
// Bench for cga_scandoubler: a reference model of the line buffer pushes the expected
// pins for every clk; a monitor pops and compares them two clk later.
module tb_cga_scandoubler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cga_scandoubler_if vid ();
    cga_scandoubler dut (.clk(clk), .rst_n(rst_n), .vid(vid));

    int n_tests = 0;
    int n_fail  = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    // Reference model state
    logic [17:0] m_mem [2][1024];
    int   m_in, m_out, m_line_len, m_wbank, m_rbank;
    logic m_hs_prev, m_synced, m_vs;
    logic [18:0] d1, d2;
    logic cur_vs;

    // Monitor statistics
    int   hs_pulses, hs_high, last_pulses, last_high;
    int   last_start_hcnt;
    logic mon_hs_prev;
    logic nonzero_seen;

    function automatic logic [18:0] model_out();
        logic [17:0] pix;
        if (m_line_len == 0) return '0;
        pix = (m_out < 1024) ? m_mem[m_rbank][m_out] : 18'h0;
        return {(m_out < 64), pix};
    endfunction

    task automatic model_reset();
        m_in = 0; m_out = 0; m_line_len = 0; m_wbank = 0; m_rbank = 0;
        m_hs_prev = 1'b0; m_synced = 1'b0; m_vs = 1'b0;
        d1 = '0; d2 = '0;
        exp_q.delete();
    endtask

    // One clk of stimulus; model advances to the state after the coming edge.
    task automatic cycle(input logic ce_i, input logic ce_o, input logic [17:0] pix,
                         input logic hs, input logic vs);
        logic rise;
        @(negedge clk);
        vid.ce_in = ce_i; vid.ce_out = ce_o;
        vid.red_in = pix[5:0]; vid.green_in = pix[11:6]; vid.blue_in = pix[17:12];
        vid.hsync_in = hs; vid.vsync_in = vs;
        rise = ce_i && hs && !m_hs_prev;
        if (rise) m_out = 0;
        else if (ce_o) m_out = (m_line_len == 0 || m_out == m_line_len - 1) ? 0 : m_out + 1;
        if (ce_i) begin
            if (rise) begin
                m_mem[1-m_wbank][0] = pix;
                m_line_len = m_synced ? ((m_in > 1024) ? 1024 : m_in) : 0;
                m_synced = 1'b1;
                m_rbank = m_wbank;
                m_wbank = 1 - m_wbank;
                m_in = 1;
            end else begin
                if (m_in < 1024) m_mem[m_wbank][m_in] = pix;
                if (m_in < 2047) m_in++;
            end
            m_hs_prev = hs;
            m_vs = vs;
        end
        exp_q.push_back({m_vs, d2});
        d2 = d1;
        d1 = model_out();
    endtask

    // One input pixel = 4 clk: ce_in on clk 0, ce_out on clk 0 and 2; junk on idle clks.
    task automatic drive_pixel(input logic [17:0] pix, input logic hs, input logic first);
        cycle(1'b1, 1'b1, pix, hs, cur_vs);
        cycle(1'b0, 1'b0, 18'($urandom), 1'($urandom), 1'($urandom));
        cycle(1'b0, 1'b1, 18'($urandom), 1'($urandom), 1'($urandom));
        if (first) begin
            last_pulses = hs_pulses; last_high = hs_high;
            hs_pulses = 0; hs_high = 0;
            last_start_hcnt = int'(vid.dbg_out_hcnt);
        end
        cycle(1'b0, 1'b0, 18'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // kind 0: value = address[5:0] on all channels, 1: constant val, 2: random
    task automatic drive_line(input int n, input int kind, input logic [5:0] val);
        logic [17:0] pix;
        for (int p = 0; p < n; p++) begin
            case (kind)
                0: pix = {3{p[5:0]}};
                1: pix = {3{val}};
                default: pix = 18'($urandom);
            endcase
            drive_pixel(pix, p < 16, p == 0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_tests++;
                if ({vid.vsync_out, vid.hsync_out, vid.blue, vid.green, vid.red} !== mon_e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t got=%h exp=%h", $time,
                             {vid.vsync_out, vid.hsync_out, vid.blue, vid.green, vid.red}, mon_e);
                end
            end
            if (vid.hsync_out && !mon_hs_prev) hs_pulses++;
            if (vid.hsync_out) hs_high++;
            mon_hs_prev = vid.hsync_out;
            if (vid.hsync_out || {vid.red, vid.green, vid.blue} != 18'h0) nonzero_seen = 1'b1;
        end
    end

    task automatic test_reset();
        vid.ce_in = 0; vid.ce_out = 0; vid.red_in = 0; vid.green_in = 0; vid.blue_in = 0;
        vid.hsync_in = 0; vid.vsync_in = 0;
        cur_vs = 0; mon_hs_prev = 0; hs_pulses = 0; hs_high = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({vid.vsync_out, vid.hsync_out, vid.blue, vid.green, vid.red} !== 20'h0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0",
                               {vid.vsync_out, vid.hsync_out, vid.blue, vid.green, vid.red});
        end
        n_tests++;
        if (vid.dbg_line_len !== 11'd0 || vid.dbg_out_hcnt !== 11'd0) begin
            n_fail++; $display("FAIL reset_counters line_len=%0d out_hcnt=%0d exp=0",
                               vid.dbg_line_len, vid.dbg_out_hcnt);
        end
        rst_n = 1'b1;
        // Two lines bring the doubler live, then a reset lands partway into a third.
        drive_line(912, 0, 6'd0);
        drive_line(912, 0, 6'd0);
        drive_line(300, 0, 6'd0);
        @(negedge clk);
        vid.ce_in = 0; vid.ce_out = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({vid.hsync_out, vid.blue, vid.green, vid.red} !== 19'h0 || vid.dbg_line_len !== 11'd0) begin
            n_fail++; $display("FAIL reset_midline got=%h line_len=%0d exp=0",
                               {vid.hsync_out, vid.blue, vid.green, vid.red}, vid.dbg_line_len);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nonzero_seen = 1'b0;
        for (int p = 0; p < 200; p++) drive_pixel(18'($urandom), 1'b0, 1'b0);
        drive_line(912, 0, 6'd0);
        n_tests++;
        if (nonzero_seen !== 1'b0) begin
            n_fail++; $display("FAIL idle_until_second_edge got=%b exp=0", nonzero_seen);
        end
        drive_line(912, 0, 6'd0);
        n_tests++;
        if (nonzero_seen !== 1'b1) begin
            n_fail++; $display("FAIL active_after_second_edge got=%b exp=1", nonzero_seen);
        end
    endtask

    task automatic test_steady();
        drive_line(912, 0, 6'd0);
        n_tests++;
        if (last_pulses != 2 || last_high != 256) begin
            n_fail++; $display("FAIL steady_hsync pulses=%0d high=%0d exp 2/256", last_pulses, last_high);
        end
        drive_line(912, 0, 6'd0);
        n_tests++;
        if (last_pulses != 2 || last_high != 256) begin
            n_fail++; $display("FAIL steady_hsync2 pulses=%0d high=%0d exp 2/256", last_pulses, last_high);
        end
    endtask

    task automatic test_pingpong();
        logic [5:0] val, exp;
        drive_line(912, 1, 6'h15);
        for (int ln = 0; ln < 2; ln++) begin
            val = (ln == 0) ? 6'h2A : 6'h00;
            exp = (ln == 0) ? 6'h15 : 6'h2A;
            for (int p = 0; p < 912; p++) begin
                drive_pixel({3{val}}, p < 16, p == 0);
                if (p == 100 || p == 700) begin
                    n_tests++;
                    if ({vid.red, vid.green, vid.blue} !== {3{exp}} || vid.hsync_out !== 1'b0) begin
                        n_fail++; $display("FAIL pingpong line=%0d p=%0d got=%h hs=%b exp=%h",
                                           ln, p, {vid.red, vid.green, vid.blue}, vid.hsync_out, {3{exp}});
                    end
                end
            end
        end
    endtask

    task automatic test_overlong();
        drive_line(1100, 2, 6'd0);
        drive_line(912, 0, 6'd0);
        n_tests++;
        if (vid.dbg_line_len !== 11'd1024) begin
            n_fail++; $display("FAIL overlong_line_len got=%0d exp=1024", vid.dbg_line_len);
        end
    endtask

    task automatic test_short_line();
        drive_line(500, 2, 6'd0);
        drive_line(912, 0, 6'd0);
        drive_line(200, 0, 6'd0);
        n_tests++;
        if (last_pulses != 4 || last_high != 512) begin
            n_fail++; $display("FAIL short_hsync pulses=%0d high=%0d exp 4/512", last_pulses, last_high);
        end
        n_tests++;
        if (last_start_hcnt != 0) begin
            n_fail++; $display("FAIL short_restart out_hcnt=%0d exp=0", last_start_hcnt);
        end
    endtask

    task automatic test_vsync();
        cur_vs = 1'b1;
        cycle(1'b1, 1'b1, 18'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        n_tests++;
        if (vid.vsync_out !== 1'b1) begin
            n_fail++; $display("FAIL vsync_rise got=%b exp=1", vid.vsync_out);
        end
        cycle(1'b0, 1'b1, 18'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        n_tests++;
        if (vid.vsync_out !== 1'b1) begin
            n_fail++; $display("FAIL vsync_hold_no_ce got=%b exp=1", vid.vsync_out);
        end
        drive_line(200, 0, 6'd0);
        cur_vs = 1'b0;
        drive_line(200, 2, 6'd0);
        n_tests++;
        if (vid.vsync_out !== 1'b0) begin
            n_fail++; $display("FAIL vsync_fall got=%b exp=0", vid.vsync_out);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_pingpong();
        test_overlong();
        test_short_line();
        test_vsync();
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
